// File: rtl/alu_pkg.sv
// Shared op-code encodings and controller state encodings for the sequenced ALU.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd3;
  localparam logic [3:0] ALU_SRL = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_XOR = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_SRA = 4'd8;
  localparam logic [3:0] ALU_MUL = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier, one partial product per cycle.
// Latency: WIDTH cycles from start to a one-cycle done pulse with the full product.
// Backpressure: none; a start while busy restarts with the new operands.
module alu_mul_seq #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [SHW-1:0]     cnt;
  logic               busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand   <= {{WIDTH{1'b0}}, a};
        mplier  <= b;
        product <= '0;
        cnt     <= '0;
        busy    <= 1'b1;
      end else if (busy) begin
        // multiplicand walks left while the multiplier bit under test walks right
        if (mplier[0]) product <= product + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (cnt == SHW'(WIDTH - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake and a sequential unsigned multiply.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL.
// Backpressure: result and flags held while out_ready is low; no accept until drained.
module alu_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  state_t               state, state_nxt;
  logic                 accept, mul_start, mul_done;
  logic [2*WIDTH-1:0]   mul_prod;
  logic [WIDTH:0]       add_ext, sub_ext;
  logic [SHW-1:0]       shamt;
  logic [WIDTH-1:0]     sc_res;
  logic                 sc_cout, sc_ovf;

  assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == ALU_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (mul_start) state_nxt = ST_MUL;
      ST_MUL:  if (mul_done)  state_nxt = ST_HOLD;
      ST_HOLD: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // SUB carry out is the no-borrow indication (a >= b unsigned)
  assign add_ext = {1'b0, a} + {1'b0, b};
  assign sub_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign shamt   = b[SHW-1:0];

  always_comb begin
    sc_res  = '0;
    sc_cout = 1'b0;
    sc_ovf  = 1'b0;
    case (op)
      ALU_AND: sc_res = a & b;
      ALU_OR:  sc_res = a | b;
      ALU_XOR: sc_res = a ^ b;
      ALU_ADD: begin
        sc_res  = add_ext[WIDTH-1:0];
        sc_cout = add_ext[WIDTH];
        sc_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        sc_res  = sub_ext[WIDTH-1:0];
        sc_cout = sub_ext[WIDTH];
        sc_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SRL: sc_res = a >> shamt;
      ALU_SLL: sc_res = a << shamt;
      ALU_SRA: sc_res = $unsigned($signed(a) >>> shamt);
      ALU_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: sc_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (accept && (op != ALU_MUL)) begin
      out_valid <= 1'b1;
      result    <= sc_res;
      cout      <= sc_cout;
      ovf       <= sc_ovf;
    end else if (mul_start) begin
      out_valid <= 1'b0;
    end else if ((state == ST_MUL) && mul_done) begin
      out_valid <= 1'b1;
      result    <= mul_prod[WIDTH-1:0];
      cout      <= |mul_prod[2*WIDTH-1:WIDTH];
      ovf       <= 1'b0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign zero = ~|result;
  assign neg  = result[WIDTH-1];

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed corner cases, then randomized traffic with random backpressure.
module tb_alu_seq;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        cout, ovf, zero, neg;

  int   checks = 0;
  int   failures = 0;
  int   ready_mode = 0;
  exp_t exp_q[$];

  alu_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .neg       (neg)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    longint      sx, sy, s, t;
    logic [63:0] u, su;
    int          sh;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = int'(y[4:0]);
    e  = '0;
    case (o)
      4'd0: e.res = x & y;
      4'd1: e.res = x | y;
      4'd2: begin
        u = {32'b0, x} + {32'b0, y};
        e.res = u[31:0];
        e.c = u[32];
        s = sx + sy;
        su = s;
        e.v = (su != {{32{su[31]}}, su[31:0]});
      end
      4'd3: begin
        e.res = x - y;
        e.c = (x >= y);
        s = sx - sy;
        su = s;
        e.v = (su != {{32{su[31]}}, su[31:0]});
      end
      4'd4: e.res = x >> sh;
      4'd5: e.res = x << sh;
      4'd6: e.res = x ^ y;
      4'd7: e.res = (sx < sy) ? 32'd1 : 32'd0;
      4'd8: begin
        t = sx >>> sh;
        su = t;
        e.res = su[31:0];
      end
      4'd9: begin
        u = {32'b0, x} * {32'b0, y};
        e.res = u[31:0];
        e.c = |u[63:32];
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Present one operation and hold it until accepted; returns just after the accept edge.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int n;
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: op=%0d never accepted within %0d cycles", o, n);
    end else begin
      exp_q.push_back(model(o, x, y));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic single(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    issue(o, x, y);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat1_valid", out_valid, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) out_ready = 1'b1;
      else if (ready_mode == 1) out_ready = ($urandom_range(0, 9) < 7);
    end
  end

  // Monitor: pops the scoreboard on each transfer and checks that stalled outputs stay put.
  initial begin
    exp_t        e;
    logic        prev_hold;
    logic [31:0] prev_res;
    logic        prev_c, prev_v;
    prev_hold = 1'b0;
    prev_res = '0;
    prev_c = 1'b0;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
        continue;
      end
      if (prev_hold) begin
        checks++;
        if (!(out_valid && result == prev_res && cout == prev_c && ovf == prev_v)) begin
          failures++;
          $display("FAIL hold_stable: got valid=%b res=%h c=%b v=%b expected valid=1 res=%h c=%b v=%b",
                   out_valid, result, cout, ovf, prev_res, prev_c, prev_v);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL spurious_output: got res=%h expected no output", result);
        end else begin
          e = exp_q.pop_front();
          if (result !== e.res || cout !== e.c || ovf !== e.v ||
              zero !== (e.res == 32'd0) || neg !== e.res[31]) begin
            failures++;
            $display("FAIL result: got res=%h c=%b v=%b z=%b n=%b expected res=%h c=%b v=%b z=%b n=%b",
                     result, cout, ovf, zero, neg, e.res, e.c, e.v, (e.res == 32'd0), e.res[31]);
          end
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_res = result;
      prev_c = cout;
      prev_v = ovf;
    end
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic        saw_ready;
    logic [31:0] corner [5];
    logic [31:0] x, y;
    logic [3:0]  o;
    corner[0] = 32'h0000_0000;
    corner[1] = 32'h0000_0001;
    corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000;
    corner[4] = 32'h7FFF_FFFF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_zero", zero, 1);
    chk("rst_result", result, 0);
    chk("rst_cout_ovf_neg", {cout, ovf, neg}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    single(4'd2, 32'hFFFF_FFFF, 32'h0000_0001);
    single(4'd3, 32'h8000_0000, 32'h0000_0001);
    single(4'd7, 32'hFFFF_FFFF, 32'h0000_0000);
    single(4'd8, 32'h8000_0000, 32'h0000_0024);
    single(4'd5, 32'h0000_0001, 32'd31);
    single(4'd13, 32'h1234_5678, 32'h9ABC_DEF0);

    issue(4'd9, 32'h0001_0000, 32'h0001_0001);
    in_valid = 1'b0;
    lat = 0;
    saw_ready = 1'b0;
    while (lat < 200) begin
      @(negedge clk);
      if (out_valid) break;
      if (in_ready) saw_ready = 1'b1;
      @(posedge clk);
      lat++;
    end
    chk("mul_latency", lat, 33);
    chk("mul_in_ready_low", saw_ready, 0);
    @(posedge clk);
    #1;

    ready_mode = 2;
    out_ready = 1'b0;
    fork
      begin
        issue(4'd2, 32'd1, 32'd2);
        issue(4'd2, 32'd10, 32'd20);
        issue(4'd2, 32'd100, 32'd200);
        in_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
        for (int j = 0; j < 3; j++) begin
          chk("stall_in_ready", in_ready, 0);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    ready_mode = 0;
    for (int k = 0; k < 100 && exp_q.size() > 0; k++) @(negedge clk);
    chk("b2b_drained", exp_q.size(), 0);
    @(posedge clk);
    #1;

    single(4'd2, 32'd5, 32'd6);
    issue(4'd9, 32'h1234_5678, 32'h0000_0003);
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midmul_rst_valid", out_valid, 0);
    chk("midmul_rst_zero", zero, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    single(4'd2, 32'd3, 32'd4);
    single(4'd6, 32'hF0F0_F0F0, 32'h0FF0_0FF0);

    ready_mode = 1;
    for (int i = 0; i < 200; i++) begin
      o = 4'($urandom_range(0, 15));
      x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 32'($urandom);
      y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 32'($urandom);
      issue(o, x, y);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    ready_mode = 0;
    for (int k = 0; k < 200 && exp_q.size() > 0; k++) @(negedge clk);
    chk("final_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
